// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART RX frame checker
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_PAR,
    CHK_STP1,
    CHK_STP2,
    DONE
  } frame_chk_state_t;

  localparam logic STOP_1   = 1'b0;
  localparam logic STOP_2   = 1'b1;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// rtl/uart_rx_frame_check_if.sv - sampler/FSM-side signal bundle of the frame checker
interface uart_rx_frame_check_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  frame_start;
  logic                  par_en;
  logic                  par_typ;
  logic                  stop_sel;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  sampled_bit;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  err_clr;
  logic                  par_err;
  logic                  stp_err;
  logic                  frame_done;
  logic                  frame_ok;
  logic [CNT_WIDTH-1:0]  par_err_cnt;
  logic [CNT_WIDTH-1:0]  stp_err_cnt;

  modport master (
    output frame_start, par_en, par_typ, stop_sel, par_chk_en, stp_chk_en,
           sampled_bit, data_in, err_clr,
    input  par_err, stp_err, frame_done, frame_ok, par_err_cnt, stp_err_cnt
  );

  modport slave (
    input  frame_start, par_en, par_typ, stop_sel, par_chk_en, stp_chk_en,
           sampled_bit, data_in, err_clr,
    output par_err, stp_err, frame_done, frame_ok, par_err_cnt, stp_err_cnt
  );
endinterface

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - expected parity bit for a deserialized word
module uart_parity_calc
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_exp
);
  // Even parity bit equals the XOR of the data; odd parity inverts it.
  assign par_exp = (^data) ^ (par_typ == PAR_ODD);
endmodule

// File: rtl/uart_rx_frame_check.sv
// rtl/uart_rx_frame_check.sv - per-frame parity/stop checker; UART_RX_ERR_CNT_EN adds error counters
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_rx_frame_check_if.slave  bus
);
  frame_chk_state_t state, state_n;
  logic par_err, par_err_n;
  logic stp_err, stp_err_n;
  logic par_typ_q, stop_sel_q;
  logic par_exp;
  logic done;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (bus.data_in),
    .par_typ (par_typ_q),
    .par_exp (par_exp)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      stop_sel_q <= STOP_1;
    end else begin
      state   <= state_n;
      par_err <= par_err_n;
      stp_err <= stp_err_n;
      if (bus.frame_start) begin
        par_typ_q  <= bus.par_typ;
        stop_sel_q <= bus.stop_sel;
      end
    end
  end

  // frame_start wins over everything, so an abort in any state simply restarts.
  always_comb begin
    state_n   = state;
    par_err_n = par_err;
    stp_err_n = stp_err;
    if (bus.frame_start) begin
      par_err_n = 1'b0;
      stp_err_n = 1'b0;
      state_n   = bus.par_en ? CHK_PAR : CHK_STP1;
    end else begin
      unique case (state)
        CHK_PAR: if (bus.par_chk_en) begin
          par_err_n = (bus.sampled_bit != par_exp);
          state_n   = CHK_STP1;
        end
        CHK_STP1: if (bus.stp_chk_en) begin
          stp_err_n = (bus.sampled_bit != 1'b1);
          state_n   = (stop_sel_q == STOP_2) ? CHK_STP2 : DONE;
        end
        CHK_STP2: if (bus.stp_chk_en) begin
          stp_err_n = stp_err | (bus.sampled_bit != 1'b1);
          state_n   = DONE;
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign done           = (state == DONE);
  assign bus.par_err    = par_err;
  assign bus.stp_err    = stp_err;
  assign bus.frame_done = done;
  assign bus.frame_ok   = done & ~(par_err | stp_err);

`ifdef UART_RX_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] par_cnt, stp_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_cnt <= '0;
      stp_cnt <= '0;
    end else if (bus.err_clr) begin
      par_cnt <= '0;
      stp_cnt <= '0;
    end else if (done) begin
      if (par_err && (par_cnt != '1)) par_cnt <= par_cnt + CNT_WIDTH'(1);
      if (stp_err && (stp_cnt != '1)) stp_cnt <= stp_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.par_err_cnt = par_cnt;
  assign bus.stp_err_cnt = stp_cnt;
`else
  logic unused_err_clr;
  assign unused_err_clr  = bus.err_clr;
  assign bus.par_err_cnt = '0;
  assign bus.stp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb/tb_uart_rx_frame_check.sv - directed self-checking bench for uart_rx_frame_check
module tb_uart_rx_frame_check;
  localparam int DW = 8;
  localparam int CW = 2;
`ifdef UART_RX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic CLK;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  uart_rx_frame_check_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  uart_rx_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int ce(input int n);
    return CNT_EN ? n : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic pe, input logic pt, input logic ss);
    bus.par_en      = pe;
    bus.par_typ     = pt;
    bus.stop_sel    = ss;
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
  endtask

  task automatic par(input logic b, input logic [DW-1:0] d);
    bus.sampled_bit = b;
    bus.data_in     = d;
    bus.par_chk_en  = 1'b1;
    cyc();
    bus.par_chk_en  = 1'b0;
  endtask

  task automatic stp(input logic b);
    bus.sampled_bit = b;
    bus.stp_chk_en  = 1'b1;
    cyc();
    bus.stp_chk_en  = 1'b0;
  endtask

  initial begin
    RST             = 1'b0;
    bus.frame_start = 1'b0;
    bus.par_en      = 1'b0;
    bus.par_typ     = 1'b0;
    bus.stop_sel    = 1'b0;
    bus.par_chk_en  = 1'b0;
    bus.stp_chk_en  = 1'b0;
    bus.sampled_bit = 1'b1;
    bus.data_in     = '0;
    bus.err_clr     = 1'b0;
    cyc();
    cyc();
    chk("rst_par_err", bus.par_err, 0);
    chk("rst_stp_err", bus.stp_err, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_frame_ok", bus.frame_ok, 0);
    chk("rst_par_cnt", bus.par_err_cnt, 0);
    chk("rst_stp_cnt", bus.stp_err_cnt, 0);
    RST = 1'b1;
    cyc();

    // Even parity, A5 has four ones -> parity bit 0 is correct
    start(1'b1, 1'b0, 1'b0);
    par(1'b0, 8'hA5);
    chk("t1_par_err", bus.par_err, 0);
    stp(1'b1);
    chk("t1_done", bus.frame_done, 1);
    chk("t1_ok", bus.frame_ok, 1);
    chk("t1_stp_err", bus.stp_err, 0);
    cyc();
    chk("t1_done_pulse", bus.frame_done, 0);
    chk("t1_ok_low", bus.frame_ok, 0);

    // Odd parity, parity bit 0 is wrong
    start(1'b1, 1'b1, 1'b0);
    par(1'b0, 8'hA5);
    chk("t2_par_err", bus.par_err, 1);
    chk("t2_no_done", bus.frame_done, 0);
    stp(1'b1);
    chk("t2_done", bus.frame_done, 1);
    chk("t2_ok", bus.frame_ok, 0);
    cyc();
    chk("t2_par_cnt", bus.par_err_cnt, ce(1));
    chk("t2_par_err_hold", bus.par_err, 1);

    // Two stop bits, second bad; stray par_chk_en ignored in CHK_STP1
    start(1'b0, 1'b0, 1'b1);
    chk("t3_flag_clr", bus.par_err, 0);
    par(1'b1, 8'h01);
    chk("t3_ignored_par", bus.par_err, 0);
    stp(1'b1);
    chk("t3_stp1_ok", bus.stp_err, 0);
    chk("t3_no_done", bus.frame_done, 0);
    stp(1'b0);
    chk("t3_stp_err", bus.stp_err, 1);
    chk("t3_done", bus.frame_done, 1);
    chk("t3_ok", bus.frame_ok, 0);
    cyc();
    chk("t3_stp_cnt", bus.stp_err_cnt, ce(1));

    // Abort in CHK_STP1 after a parity error
    start(1'b1, 1'b0, 1'b0);
    par(1'b1, 8'hA5);
    chk("t4_par_err", bus.par_err, 1);
    start(1'b0, 1'b0, 1'b0);
    chk("t4_abort_clr", bus.par_err, 0);
    chk("t4_abort_no_done", bus.frame_done, 0);
    stp(1'b1);
    chk("t4_done", bus.frame_done, 1);
    chk("t4_ok", bus.frame_ok, 1);
    cyc();
    chk("t4_par_cnt", bus.par_err_cnt, ce(1));
    chk("t4_stp_cnt", bus.stp_err_cnt, ce(1));

    // Five back-to-back stop-error frames saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      start(1'b0, 1'b0, 1'b0);
      stp(1'b0);
      chk("t5_done", bus.frame_done, 1);
    end
    cyc();
    chk("t5_stp_sat", bus.stp_err_cnt, ce(3));

    // err_clr beats the increment of a sixth error frame
    start(1'b0, 1'b0, 1'b0);
    stp(1'b0);
    chk("t6_done", bus.frame_done, 1);
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
    chk("t6_stp_clr", bus.stp_err_cnt, 0);
    chk("t6_par_clr", bus.par_err_cnt, 0);

    // Asynchronous reset in CHK_PAR with a nonzero counter
    start(1'b1, 1'b1, 1'b0);
    par(1'b0, 8'hA5);
    stp(1'b1);
    start(1'b1, 1'b0, 1'b0);
    chk("t7_par_cnt", bus.par_err_cnt, ce(1));
    #2 RST = 1'b0;
    #1;
    chk("t7_rst_par_cnt", bus.par_err_cnt, 0);
    chk("t7_rst_par_err", bus.par_err, 0);
    chk("t7_rst_stp_err", bus.stp_err, 0);
    chk("t7_rst_done", bus.frame_done, 0);
    chk("t7_rst_ok", bus.frame_ok, 0);
    cyc();
    RST = 1'b1;
    cyc();
    start(1'b0, 1'b0, 1'b0);
    bus.data_in = 8'h00;
    stp(1'b1);
    chk("t7_clean_done", bus.frame_done, 1);
    chk("t7_clean_ok", bus.frame_ok, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
